// File: rtl/timer_dev_pkg.sv
// Shared encodings for the timer_dev device: FSM states, register offsets and CTRL fields.
// Optional prescaler is enabled with TIMER_PRESCALE_EN.
package timer_dev_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_e;

   localparam logic [1:0] TIMER_CTRL   = 2'd0;
   localparam logic [1:0] TIMER_PRESET = 2'd1;
   localparam logic [1:0] TIMER_COUNT  = 2'd2;
   localparam logic [1:0] TIMER_PSC    = 2'd3;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM      = 3;
   localparam int CTRL_W       = 4;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   localparam int PSC_W = 8;

   // MODE=1x is deliberately folded onto one-shot.
   function automatic logic is_reload(input logic [1:0] mode);
      return (mode == MODE_RELOAD);
   endfunction

endpackage

// File: rtl/timer_dev_if.sv
// CPU device-bus port of the timer: decoded word address, write strobe, data and IRQ.
interface timer_dev_if #(parameter int CNT_W = 32) ();
   logic [1:0]       ADDR;
   logic             WE;
   logic [CNT_W-1:0] DATA_IN;
   logic [CNT_W-1:0] DATA_OUT;
   logic             IRQ;

   modport master (output ADDR, WE, DATA_IN, input DATA_OUT, IRQ);
   modport slave  (input ADDR, WE, DATA_IN, output DATA_OUT, IRQ);
endinterface

// File: rtl/timer_dev_prescaler.sv
// PSC register plus tick generator for the timer; only compiled with TIMER_PRESCALE_EN.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler
   import timer_dev_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_psc_we,
   input  logic [PSC_W-1:0] i_psc_din,
   input  logic             i_clr,
   input  logic             i_run,
   output logic [PSC_W-1:0] o_psc,
   output logic             o_tick
);

   logic [PSC_W-1:0] r_psc;
   logic [PSC_W-1:0] r_pcnt;

   assign o_psc  = r_psc;
   assign o_tick = (r_pcnt == r_psc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_psc  <= '0;
         r_pcnt <= '0;
      end else begin
         if (i_psc_we) r_psc <= i_psc_din;
         if (i_clr) begin
            r_pcnt <= '0;
         end else if (i_run) begin
            r_pcnt <= o_tick ? '0 : r_pcnt + 1'b1;
         end
      end
   end

endmodule
`endif

// File: rtl/timer_dev.sv
// Memory-mapped down-counter timer with one-shot / auto-reload modes and a maskable IRQ.
// Define TIMER_PRESCALE_EN to add the PSC register at ADDR=3 and a count prescaler.
//
// state | meaning
// IDLE  | waiting for CTRL.EN
// LOAD  | COUNT <= PRESET
// CNT   | counting down, one step per tick
// INT   | terminal count reached; reload or disable
module timer_dev
   import timer_dev_pkg::*;
#(
   parameter int CNT_W = 32
)
(
   input logic        clk,
   input logic        reset,
   timer_dev_if.slave bus
);

   state_e            r_state;
   logic [CTRL_W-1:0] r_ctrl;
   logic [CNT_W-1:0]  r_preset;
   logic [CNT_W-1:0]  r_count;
   logic              r_pend;

   logic              w_ctrl_wr;
   logic              w_preset_wr;
   logic              w_en;
   logic              w_reload;
   logic              w_tick;
   logic [PSC_W-1:0]  w_psc;
   logic [CNT_W-1:0]  w_rdata;

   assign w_ctrl_wr   = bus.WE && (bus.ADDR == TIMER_CTRL);
   assign w_preset_wr = bus.WE && (bus.ADDR == TIMER_PRESET);
   assign w_en        = r_ctrl[CTRL_EN];
   assign w_reload    = is_reload(r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO]);

`ifdef TIMER_PRESCALE_EN
   logic w_psc_wr;
   assign w_psc_wr = bus.WE && (bus.ADDR == TIMER_PSC);

   timer_prescaler u_prescaler (
      .clk       (clk),
      .rst_n     (reset),
      .i_psc_we  (w_psc_wr),
      .i_psc_din (bus.DATA_IN[PSC_W-1:0]),
      .i_clr     (r_state == ST_LOAD),
      .i_run     ((r_state == ST_CNT) && w_en),
      .o_psc     (w_psc),
      .o_tick    (w_tick)
   );
`else
   assign w_tick = 1'b1;
   assign w_psc  = '0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_ctrl   <= '0;
         r_preset <= '0;
         r_count  <= '0;
         r_pend   <= 1'b0;
      end else begin
         if (w_preset_wr) r_preset <= bus.DATA_IN;

         case (r_state)
            ST_IDLE: begin
               if (w_en) r_state <= ST_LOAD;
            end
            ST_LOAD: begin
               r_count <= r_preset;
               r_state <= ST_CNT;
            end
            ST_CNT: begin
               if (!w_en) begin
                  r_state <= ST_IDLE;
               end else if (w_tick) begin
                  // PRESET=0 terminates just like PRESET=1.
                  if (r_count < CNT_W'(2)) begin
                     r_count <= '0;
                     r_pend  <= 1'b1;
                     r_state <= ST_INT;
                  end else begin
                     r_count <= r_count - 1'b1;
                  end
               end
            end
            ST_INT: begin
               if (w_reload) begin
                  r_pend  <= 1'b0;
                  r_state <= ST_LOAD;
               end else begin
                  r_ctrl[CTRL_EN] <= 1'b0;
                  r_state         <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         // A CTRL write overrides any same-edge FSM update of CTRL or the pending flag.
         if (w_ctrl_wr) begin
            r_ctrl <= bus.DATA_IN[CTRL_W-1:0];
            r_pend <= 1'b0;
         end
      end
   end

   always_comb begin
      w_rdata = '0;
      case (bus.ADDR)
         TIMER_CTRL:   w_rdata = CNT_W'(r_ctrl);
         TIMER_PRESET: w_rdata = r_preset;
         TIMER_COUNT:  w_rdata = r_count;
         TIMER_PSC:    w_rdata = CNT_W'(w_psc);
         default:      w_rdata = '0;
      endcase
   end

   assign bus.DATA_OUT = w_rdata;
   assign bus.IRQ      = r_pend & r_ctrl[CTRL_IM];

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: directed scenarios with hand-derived timing, then random traffic vs a reference model.
module tb_timer_dev;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk  = 0;
   int   n_pass = 0;

   timer_dev_if #(.CNT_W(32)) bus ();

   timer_dev #(.CNT_W(32)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: register file plus a "where in the period are we" tracker.
   logic        m_en, m_im;
   logic [1:0]  m_mode;
   logic [31:0] m_preset, m_count;
   logic        m_pend;
   logic [7:0]  m_psc, m_pc;
   int          m_where;   // 0 waiting, 1 about to load, 2 counting, 3 just fired

   task automatic model_reset();
      m_en = 0; m_im = 0; m_mode = 0; m_preset = 0; m_count = 0;
      m_pend = 0; m_psc = 0; m_pc = 0; m_where = 0;
   endtask

   task automatic model_edge(input logic we, input logic [1:0] a, input logic [31:0] d);
      logic        n_en, n_pend;
      logic [31:0] n_count;
      logic [7:0]  n_pc;
      int          n_where;
      n_en = m_en; n_pend = m_pend; n_count = m_count; n_pc = m_pc; n_where = m_where;
      if (m_where == 0) begin
         if (m_en) n_where = 1;
      end else if (m_where == 1) begin
         n_count = m_preset; n_pc = 0; n_where = 2;
      end else if (m_where == 2) begin
         if (!m_en) n_where = 0;
         else if (m_pc != m_psc) n_pc = m_pc + 8'd1;
         else begin
            n_pc = 0;
            if (m_count > 1) n_count = m_count - 1;
            else begin n_count = 0; n_pend = 1; n_where = 3; end
         end
      end else begin
         if (m_mode == 2'b01) begin n_pend = 0; n_where = 1; end
         else begin n_en = 0; n_where = 0; end
      end
      if (we && a == 2'd0) begin
         n_en = d[0]; m_mode = d[2:1]; m_im = d[3]; n_pend = 0;
      end
      if (we && a == 2'd1) m_preset = d;
`ifdef TIMER_PRESCALE_EN
      if (we && a == 2'd3) m_psc = d[7:0];
`endif
      m_en = n_en; m_pend = n_pend; m_count = n_count; m_pc = n_pc; m_where = n_where;
   endtask

   function automatic logic [31:0] model_read(input logic [1:0] a);
      case (a)
         2'd0: return {28'd0, m_im, m_mode, m_en};
         2'd1: return m_preset;
         2'd2: return m_count;
         default: return {24'd0, m_psc};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
   endtask

   task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
      bus.ADDR = a;
      #1;
      chk(tag, bus.DATA_OUT, exp);
   endtask

   task automatic cyc(input logic we, input logic [1:0] a, input logic [31:0] d);
      bus.WE = we; bus.ADDR = a; bus.DATA_IN = d;
      @(posedge clk);
      model_edge(we, a, d);
      @(negedge clk);
      bus.WE = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 2'd2, 32'd0);
   endtask

   initial begin
      bus.WE = 0; bus.ADDR = 0; bus.DATA_IN = 0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // reset state
      rd("rst_ctrl", 2'd0, 0); rd("rst_preset", 2'd1, 0); rd("rst_count", 2'd2, 0);
      chk("rst_irq", bus.IRQ, 0);
      rd("rst_psc", 2'd3, 0);

      // one-shot, PRESET=5: COUNT 5..0 after edges 2..7, IRQ from edge 7
      cyc(1, 2'd1, 5);
      cyc(1, 2'd0, 32'h9);
      for (int k = 1; k <= 9; k++) begin
         idle(1);
         if (k >= 2) rd($sformatf("os_count_e%0d", k), 2'd2, (k >= 7) ? 0 : 7 - k);
         chk($sformatf("os_irq_e%0d", k), bus.IRQ, (k >= 7));
         if (k >= 8) rd($sformatf("os_ctrl_e%0d", k), 2'd0, 32'h8);
      end
      cyc(1, 2'd0, 32'h8);
      chk("os_irq_clr", bus.IRQ, 0);

      // auto-reload, PRESET=3: 1-cycle pulse every 5 cycles
      cyc(1, 2'd1, 3);
      cyc(1, 2'd0, 32'hB);
      for (int k = 1; k <= 22; k++) begin
         idle(1);
         chk($sformatf("ar_irq_e%0d", k), bus.IRQ, (k >= 5) && ((k - 5) % 5 == 0));
      end
      rd("ar_ctrl", 2'd0, 32'hB);
      cyc(1, 2'd0, 0);
      idle(4);

      // pause mid-count then re-enable reloads from PRESET
      cyc(1, 2'd1, 6);
      cyc(1, 2'd0, 32'h9);
      idle(4);
      rd("pa_count_pre", 2'd2, 4);
      cyc(1, 2'd0, 32'h8);
      for (int k = 0; k < 4; k++) begin
         idle(1);
         rd($sformatf("pa_hold%0d", k), 2'd2, 3);
         chk($sformatf("pa_irq%0d", k), bus.IRQ, 0);
      end
      cyc(1, 2'd0, 32'h9);
      idle(2);
      rd("pa_reload", 2'd2, 6);
      cyc(1, 2'd0, 0);
      idle(3);

      // masked, PRESET=0: terminal count after edge 3, one-shot clears EN at edge 4
      cyc(1, 2'd1, 0);
      cyc(1, 2'd0, 32'h1);
      idle(3);
      rd("mk_ctrl_e3", 2'd0, 32'h1);
      chk("mk_irq_e3", bus.IRQ, 0);
      idle(1);
      rd("mk_ctrl_e4", 2'd0, 32'h0);
      chk("mk_irq_e4", bus.IRQ, 0);

      // PRESET and COUNT writes mid-count do not disturb the countdown
      cyc(1, 2'd1, 5);
      cyc(1, 2'd0, 32'h9);
      idle(2);
      cyc(1, 2'd1, 100);
      rd("wr_count_e3", 2'd2, 4);
      cyc(1, 2'd2, 32'h55);
      rd("wr_count_e4", 2'd2, 3);
      rd("wr_preset", 2'd1, 100);
      idle(1);
      rd("wr_count_e5", 2'd2, 2);
      cyc(1, 2'd0, 0);
      idle(3);

`ifdef TIMER_PRESCALE_EN
      cyc(1, 2'd3, 2);
      cyc(1, 2'd1, 2);
      cyc(1, 2'd0, 32'h1);
      for (int k = 1; k <= 9; k++) begin
         idle(1);
         if (k >= 2) rd($sformatf("ps_count_e%0d", k), 2'd2, (k >= 8) ? 0 : (k >= 5) ? 1 : 2);
      end
      rd("ps_psc", 2'd3, 2);
      cyc(1, 2'd0, 0);
      cyc(1, 2'd3, 0);
      idle(3);
`endif

      // reset while IRQ is high
      cyc(1, 2'd1, 1);
      cyc(1, 2'd0, 32'h9);
      idle(3);
      chk("rs_irq_before", bus.IRQ, 1);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rs_irq_now", bus.IRQ, 0);
      rd("rs_ctrl", 2'd0, 0); rd("rs_count", 2'd2, 0);
      @(negedge clk);
      rd("rs_preset", 2'd1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(4);
      rd("rs_idle_count", 2'd2, 0);
      rd("rs_idle_ctrl", 2'd0, 0);

      // random traffic against the model
      for (int i = 0; i < 600; i++) begin
         int r;
         logic [31:0] d;
         r = $urandom_range(0, 99);
         if (r < 6) begin
            d = $urandom;
            d[0] = ($urandom_range(0, 9) < 7);
            cyc(1, 2'd0, d);
         end else if (r < 11) cyc(1, 2'd1, $urandom_range(0, 7));
         else if (r < 13) cyc(1, 2'd2, $urandom);
         else if (r < 15) cyc(1, 2'd3, $urandom_range(0, 3));
         else cyc(0, 2'($urandom_range(0, 3)), $urandom);
         chk("rnd_irq", bus.IRQ, m_pend & m_im);
         begin
            logic [1:0] a;
            a = 2'($urandom_range(0, 3));
            rd($sformatf("rnd_rd%0d", a), a, model_read(a));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
